// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared constants and state types for the memory-mapped UART
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Register addresses, compared against the full 32-bit MEM-stage address
  localparam logic [31:0] UART_TXD = 32'h4000_0018;
  localparam logic [31:0] UART_RXD = 32'h4000_001C;
  localparam logic [31:0] UART_CON = 32'h4000_0020;

  // CON register bit positions
  localparam int CON_TX_IRQ_EN = 0;
  localparam int CON_RX_IRQ_EN = 1;
  localparam int CON_TX_DONE   = 2;
  localparam int CON_RX_VALID  = 3;
  localparam int CON_TX_BUSY   = 4;
  localparam int CON_OVERRUN   = 5;
  localparam int CON_FRAME_ERR = 6;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_mmio_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_mmio_if
//  Description : MEM-stage bus bundle (strobes, address, data) for the UART
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_mmio_if;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output mem_rd, output mem_wr, output addr, output wdata, input rdata);
  modport slave  (input mem_rd, input mem_wr, input addr, input wdata, output rdata);
endinterface
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ============================================================================
//  Module      : uart_baud_tick
//  Description : Free-running divider producing a 1-cycle 16x oversample tick
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_tick #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Count 0..DIV-1 and wrap
  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
  end

  // Divider register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == LAST);

endmodule
`default_nettype wire

// File: rtl/uart_mmio.sv
`default_nettype none
// ============================================================================
//  Module      : uart_mmio
//  Description : Memory-mapped 8N1 UART (TXD/RXD/CON registers, rx/tx irqs)
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_mmio
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 100000000,
  parameter int BAUD     = 9600
) (
  input  logic        clk,
  input  logic        reset,
  uart_mmio_if.slave  bus,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        rx_irq,
  output logic        tx_irq
);
  localparam int DIV = CLK_FREQ / (BAUD * 16);

  generate
    if (DIV < 2) begin : g_div_check
      $error("uart_mmio: CLK_FREQ/(BAUD*16) must be at least 2");
    end
  endgenerate

  logic tick;
  uart_baud_tick #(.DIV(DIV)) u_tick (.clk(clk), .reset(reset), .tick(tick));

  // Address decode and access strobes
  logic sel_txd, sel_rxd, sel_con, wr_txd, wr_con, rd_rxd, rd_con;
  assign sel_txd = (bus.addr == UART_TXD);
  assign sel_rxd = (bus.addr == UART_RXD);
  assign sel_con = (bus.addr == UART_CON);
  assign wr_txd  = bus.mem_wr & sel_txd;
  assign wr_con  = bus.mem_wr & sel_con;
  assign rd_rxd  = bus.mem_rd & sel_rxd;
  assign rd_con  = bus.mem_rd & sel_con;

  logic wdata_unused;
  assign wdata_unused = ^bus.wdata[31:8];

  // Transmit state
  tx_state_t   tx_state_q, tx_state_d;
  logic [3:0]  tx_tcnt_q, tx_tcnt_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  txd_q, txd_d;
  logic        tx_busy_q, tx_busy_d, tx_done_q, tx_done_d, tx_line_q, tx_line_d;
  logic        tx_finish;

  // Receive state
  rx_state_t   rx_state_q, rx_state_d;
  logic [1:0]  rx_sync_q, rx_sync_d;
  logic [3:0]  rx_tcnt_q, rx_tcnt_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d, rxd_q, rxd_d;
  logic        rx_valid_q, rx_valid_d, overrun_q, overrun_d, frame_err_q, frame_err_d;
  logic        rx_load, rx_ferr, rx_line;

  logic [1:0]  con_en_q, con_en_d;
  logic [6:0]  con_val;

  // TX FSM: accept a byte when idle, wait for a tick, then shift start/data/stop
  always_comb begin
    tx_state_d = tx_state_q;
    tx_tcnt_d  = tx_tcnt_q;
    tx_bit_d   = tx_bit_q;
    txd_d      = txd_q;
    tx_busy_d  = tx_busy_q;
    tx_finish  = 1'b0;
    tx_line_d  = 1'b1;
    case (tx_state_q)
      TX_IDLE: begin
        if (wr_txd && !tx_busy_q) begin
          txd_d     = bus.wdata[7:0];
          tx_busy_d = 1'b1;
        end else if (tx_busy_q && tick) begin
          tx_state_d = TX_START;
          tx_tcnt_d  = 4'd0;
        end
      end
      TX_START: if (tick) begin
        tx_tcnt_d = tx_tcnt_q + 4'd1;
        if (tx_tcnt_q == 4'd15) begin
          tx_state_d = TX_DATA;
          tx_bit_d   = 3'd0;
        end
      end
      TX_DATA: if (tick) begin
        tx_tcnt_d = tx_tcnt_q + 4'd1;
        if (tx_tcnt_q == 4'd15) begin
          if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
          else                  tx_bit_d   = tx_bit_q + 3'd1;
        end
      end
      TX_STOP: if (tick) begin
        tx_tcnt_d = tx_tcnt_q + 4'd1;
        if (tx_tcnt_q == 4'd15) begin
          tx_state_d = TX_IDLE;
          tx_busy_d  = 1'b0;
          tx_finish  = 1'b1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
    // Line level is registered from the next state so the pin never glitches
    case (tx_state_d)
      TX_START: tx_line_d = 1'b0;
      TX_DATA:  tx_line_d = txd_d[tx_bit_d];
      default:  tx_line_d = 1'b1;
    endcase
  end

  // RX FSM: detect start, sample mid-bit (tick 8) for data and stop
  always_comb begin
    rx_sync_d  = {rx_sync_q[0], uart_rx};
    rx_line    = rx_sync_q[1];
    rx_state_d = rx_state_q;
    rx_tcnt_d  = rx_tcnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_load    = 1'b0;
    rx_ferr    = 1'b0;
    case (rx_state_q)
      RX_IDLE: if (!rx_line) begin
        rx_state_d = RX_START;
        rx_tcnt_d  = 4'd0;
      end
      RX_START: if (tick) begin
        rx_tcnt_d = rx_tcnt_q + 4'd1;
        if (rx_tcnt_q == 4'd7 && rx_line) begin
          rx_state_d = RX_IDLE;
        end else if (rx_tcnt_q == 4'd15) begin
          rx_state_d = RX_DATA;
          rx_bit_d   = 3'd0;
        end
      end
      RX_DATA: if (tick) begin
        rx_tcnt_d = rx_tcnt_q + 4'd1;
        if (rx_tcnt_q == 4'd7) rx_shift_d = {rx_line, rx_shift_q[7:1]};
        if (rx_tcnt_q == 4'd15) begin
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end
      end
      RX_STOP: if (tick) begin
        rx_tcnt_d = rx_tcnt_q + 4'd1;
        if (rx_tcnt_q == 4'd7) begin
          rx_state_d = RX_IDLE;
          rx_load    = rx_line;
          rx_ferr    = !rx_line;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Register file: sticky status bits, set beats a same-cycle read clear
  always_comb begin
    con_en_d    = wr_con ? bus.wdata[1:0] : con_en_q;
    tx_done_d   = tx_finish ? 1'b1 : (rd_con ? 1'b0 : tx_done_q);
    rxd_d       = rx_load ? rx_shift_q : rxd_q;
    rx_valid_d  = rx_load ? 1'b1 : (rd_rxd ? 1'b0 : rx_valid_q);
    overrun_d   = (rx_load && rx_valid_q) ? 1'b1 : (rd_con ? 1'b0 : overrun_q);
    frame_err_d = rx_ferr ? 1'b1 : (rd_con ? 1'b0 : frame_err_q);
  end

  // All state flops; async active-low reset leaves the line idle-high
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state_q  <= TX_IDLE;
      tx_tcnt_q   <= 4'd0;
      tx_bit_q    <= 3'd0;
      txd_q       <= 8'd0;
      tx_busy_q   <= 1'b0;
      tx_done_q   <= 1'b0;
      tx_line_q   <= 1'b1;
      rx_state_q  <= RX_IDLE;
      rx_sync_q   <= 2'b11;
      rx_tcnt_q   <= 4'd0;
      rx_bit_q    <= 3'd0;
      rx_shift_q  <= 8'd0;
      rxd_q       <= 8'd0;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      con_en_q    <= 2'b00;
    end else begin
      tx_state_q  <= tx_state_d;
      tx_tcnt_q   <= tx_tcnt_d;
      tx_bit_q    <= tx_bit_d;
      txd_q       <= txd_d;
      tx_busy_q   <= tx_busy_d;
      tx_done_q   <= tx_done_d;
      tx_line_q   <= tx_line_d;
      rx_state_q  <= rx_state_d;
      rx_sync_q   <= rx_sync_d;
      rx_tcnt_q   <= rx_tcnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      rxd_q       <= rxd_d;
      rx_valid_q  <= rx_valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
      con_en_q    <= con_en_d;
    end
  end

  always_comb begin
    con_val                = 7'd0;
    con_val[CON_TX_IRQ_EN] = con_en_q[0];
    con_val[CON_RX_IRQ_EN] = con_en_q[1];
    con_val[CON_TX_DONE]   = tx_done_q;
    con_val[CON_RX_VALID]  = rx_valid_q;
    con_val[CON_TX_BUSY]   = tx_busy_q;
    con_val[CON_OVERRUN]   = overrun_q;
    con_val[CON_FRAME_ERR] = frame_err_q;
  end

  // Read mux: zero unless a read strobe hits a mapped address
  always_comb begin
    bus.rdata = 32'd0;
    if (bus.mem_rd) begin
      if (sel_txd)      bus.rdata = {24'd0, txd_q};
      else if (sel_rxd) bus.rdata = {24'd0, rxd_q};
      else if (sel_con) bus.rdata = {25'd0, con_val};
    end
  end

  assign uart_tx = tx_line_q;
  assign tx_irq  = con_en_q[0] & tx_done_q;
  assign rx_irq  = con_en_q[1] & rx_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_mmio.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_mmio
//  Description : Self-checking bench for uart_mmio (register map, TX, RX)
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_mmio;
  localparam int CLK_FREQ = 1600000;
  localparam int BAUD     = 10000;
  localparam int BIT      = 160;
  localparam logic [31:0] A_TXD = 32'h4000_0018;
  localparam logic [31:0] A_RXD = 32'h4000_001C;
  localparam logic [31:0] A_CON = 32'h4000_0020;
  localparam logic [31:0] A_BAD = 32'h4000_0024;

  localparam int OP_RD   = 0;
  localparam int OP_WR   = 1;
  localparam int OP_PEEK = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic uart_rx = 1'b1;
  logic uart_tx, rx_irq, tx_irq;

  uart_mmio_if bus ();

  uart_mmio #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave),
    .uart_rx(uart_rx), .uart_tx(uart_tx), .rx_irq(rx_irq), .tx_irq(tx_irq)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int          op;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.mem_wr = 1'b1; bus.addr = a; bus.wdata = d;
    @(negedge clk);
    bus.mem_wr = 1'b0; bus.addr = 32'd0; bus.wdata = 32'd0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.mem_rd = 1'b1; bus.addr = a;
    #1 d = bus.rdata;
    @(negedge clk);
    bus.mem_rd = 1'b0; bus.addr = 32'd0;
  endtask

  task automatic read_check(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(a, d);
    check(name, d, exp);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int stop_len);
    @(negedge clk);
    uart_rx = 1'b0;
    wait_cycles(BIT);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      wait_cycles(BIT);
    end
    uart_rx = stop_bit;
    wait_cycles(stop_len);
    uart_rx = 1'b1;
  endtask

  // Waits (bounded) for the start edge, then samples every bit at its centre.
  // With inject set, a TXD write is issued right after data bit 0 is sampled.
  task automatic capture_tx(input string name, input logic inject, input logic [31:0] inj_data,
                            output logic [7:0] b, output logic stop_bit);
    int k;
    logic seen;
    seen = 1'b0;
    b = 8'h00;
    stop_bit = 1'b0;
    for (k = 0; k < 20; k++) begin
      if (uart_tx == 1'b0) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({name, "_start_edge"}, {31'd0, seen}, 32'd1);
    if (seen) begin
      wait_cycles(BIT / 2);
      check({name, "_start_bit"}, {31'd0, uart_tx}, 32'd0);
      for (int i = 0; i < 8; i++) begin
        wait_cycles((inject && i == 1) ? BIT - 2 : BIT);
        b[i] = uart_tx;
        if (inject && i == 0) bus_write(A_TXD, inj_data);
      end
      wait_cycles(BIT);
      stop_bit = uart_tx;
    end
  endtask

  task automatic wait_high(input string name, output logic got, ref logic sig, input int budget);
    got = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (sig) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check(name, {31'd0, got}, 32'd1);
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  b;
    logic        sb, got, all_high;
    logic [31:0] d;

    bus.mem_rd = 1'b0; bus.mem_wr = 1'b0; bus.addr = 32'd0; bus.wdata = 32'd0;

    vecs[0]  = '{OP_RD,   A_TXD,        32'd0,         32'h0000_0000, "rst_txd"};
    vecs[1]  = '{OP_RD,   A_RXD,        32'd0,         32'h0000_0000, "rst_rxd"};
    vecs[2]  = '{OP_RD,   A_CON,        32'd0,         32'h0000_0000, "rst_con"};
    vecs[3]  = '{OP_RD,   A_BAD,        32'd0,         32'h0000_0000, "unmapped_24"};
    vecs[4]  = '{OP_WR,   A_CON,        32'hFFFF_FFFF, 32'h0,         "wr_con_all"};
    vecs[5]  = '{OP_RD,   A_CON,        32'd0,         32'h0000_0003, "con_only_en_bits"};
    vecs[6]  = '{OP_PEEK, A_CON,        32'd0,         32'h0000_0000, "rdata_no_strobe"};
    vecs[7]  = '{OP_RD,   32'h0000_0020, 32'd0,        32'h0000_0000, "partial_addr"};
    vecs[8]  = '{OP_WR,   A_CON,        32'h0000_0002, 32'h0,         "wr_con_2"};
    vecs[9]  = '{OP_RD,   A_CON,        32'd0,         32'h0000_0002, "con_rx_en"};
    vecs[10] = '{OP_WR,   A_CON,        32'h0000_0000, 32'h0,         "wr_con_0"};
    vecs[11] = '{OP_RD,   A_CON,        32'd0,         32'h0000_0000, "con_cleared"};

    // Reset state
    wait_cycles(5);
    bus.mem_rd = 1'b1; bus.addr = A_CON;
    #1;
    check("rst_uart_tx", {31'd0, uart_tx}, 32'd1);
    check("rst_tx_irq",  {31'd0, tx_irq},  32'd0);
    check("rst_rx_irq",  {31'd0, rx_irq},  32'd0);
    check("rst_rdata",   bus.rdata,        32'd0);
    @(negedge clk);
    bus.mem_rd = 1'b0; bus.addr = 32'd0;
    reset = 1'b1;
    wait_cycles(2);

    // Register-map vector table
    for (int i = 0; i < 12; i++) begin
      case (vecs[i].op)
        OP_WR: bus_write(vecs[i].addr, vecs[i].data);
        OP_RD: read_check(vecs[i].name, vecs[i].addr, vecs[i].exp);
        default: begin
          @(negedge clk);
          bus.addr = vecs[i].addr;
          #1 check(vecs[i].name, bus.rdata, vecs[i].exp);
          bus.addr = 32'd0;
        end
      endcase
    end

    // TX 0x55 with tx irq enabled
    bus_write(A_CON, 32'h1);
    bus_write(A_TXD, 32'h55);
    capture_tx("tx55", 1'b0, 32'd0, b, sb);
    check("tx55_byte", {24'd0, b}, 32'h55);
    check("tx55_stop", {31'd0, sb}, 32'd1);
    wait_high("tx55_irq", got, tx_irq, 200);
    read_check("tx55_con", A_CON, 32'h05);
    read_check("tx55_con_again", A_CON, 32'h01);
    #1 check("tx55_irq_cleared", {31'd0, tx_irq}, 32'd0);

    // RX 0xA3 with rx irq enabled
    bus_write(A_CON, 32'h2);
    send_frame(8'hA3, 1'b1, BIT);
    wait_high("rxa3_irq", got, rx_irq, 40);
    read_check("rxa3_con", A_CON, 32'h0A);
    read_check("rxa3_rxd", A_RXD, 32'hA3);
    #1 check("rxa3_irq_cleared", {31'd0, rx_irq}, 32'd0);
    read_check("rxa3_con_after", A_CON, 32'h02);

    // Short glitch: false start, no flags
    @(negedge clk);
    uart_rx = 1'b0;
    wait_cycles(40);
    uart_rx = 1'b1;
    wait_cycles(300);
    read_check("glitch_con", A_CON, 32'h02);

    // Framing error: stop bit low
    send_frame(8'h3C, 1'b0, 100);
    wait_cycles(200);
    read_check("ferr_con", A_CON, 32'h42);
    read_check("ferr_con_cleared", A_CON, 32'h02);
    read_check("ferr_rxd_kept", A_RXD, 32'hA3);

    // Overrun: two frames without reading
    send_frame(8'h5A, 1'b1, BIT);
    send_frame(8'hC3, 1'b1, BIT);
    wait_cycles(20);
    read_check("ovr_con", A_CON, 32'h2A);
    read_check("ovr_rxd", A_RXD, 32'hC3);
    read_check("ovr_con_after", A_CON, 32'h02);

    // Write to TXD while busy is ignored
    bus_write(A_CON, 32'h0);
    bus_write(A_TXD, 32'h11);
    capture_tx("tx11", 1'b1, 32'h22, b, sb);
    check("tx11_byte", {24'd0, b}, 32'h11);
    check("tx11_stop", {31'd0, sb}, 32'd1);
    wait_cycles(200);
    read_check("tx11_txd", A_TXD, 32'h11);
    read_check("tx11_bad_addr", A_BAD, 32'h0);
    read_check("tx11_con_done", A_CON, 32'h04);

    // Reset during TX data bit 0 (0x80 puts a low bit there)
    bus_write(A_CON, 32'h3);
    bus_write(A_TXD, 32'h80);
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (uart_tx == 1'b0) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("rst_mid_start_edge", {31'd0, got}, 32'd1);
    wait_cycles(BIT / 2 + BIT);
    check("rst_mid_bit0_low", {31'd0, uart_tx}, 32'd0);
    reset = 1'b0;
    #1 check("rst_mid_tx_high", {31'd0, uart_tx}, 32'd1);
    wait_cycles(3);
    reset = 1'b1;
    read_check("rst_mid_con", A_CON, 32'h0);
    read_check("rst_mid_txd", A_TXD, 32'h0);
    all_high = 1'b1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) all_high = 1'b0;
    end
    check("rst_mid_tx_idle", {31'd0, all_high}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
